// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_ctrl_pkg
// Purpose  : Shared types and constants for the PE array controller.
//            Holds the sequencer state enum, the default array geometry and
//            pipeline latency, and the index of the bias word in the
//            weight/bias load stream.
// Revision : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_WGT = 3'd1,
        ST_COMPUTE  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } pe_state_t;

    localparam int unsigned DEF_PE_ARR_SIZE = 9;
    localparam int unsigned DEF_PE_LATENCY  = 5;

    // The bias follows the weights, so it is the word right after the last one.
    localparam int unsigned BIAS_WORD_IDX   = DEF_PE_ARR_SIZE;

endpackage
`default_nettype wire

// File: rtl/pe_valid_delay.sv
`default_nettype none
// ============================================================================
// Module   : pe_valid_delay
// Purpose  : DEPTH-stage shift register carrying the result-valid bit
//            alongside the PE array pipeline.
// Ports    : clk, rst_n (async, active-low)
//            in_vld  - valid bit entering stage 0
//            out_vld - valid bit leaving the last stage
//            empty   - no stage holds a valid bit
// Revision : 1.0 - initial release
// ============================================================================
module pe_valid_delay
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_PE_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld,
    output logic empty
);

    logic [DEPTH-1:0] r_stage;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_stage <= '0;
                else        r_stage <= in_vld;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_stage <= '0;
                else        r_stage <= {r_stage[DEPTH-2:0], in_vld};
            end
        end
    endgenerate

    assign out_vld = r_stage[DEPTH-1];
    assign empty   = ~|r_stage;

endmodule
`default_nettype wire

// File: rtl/pe_arr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_arr_ctrl
// Purpose  : Job sequencer for the PE array. Loads weights and bias from a
//            serial bus, streams IFM windows into the array and tags each
//            array result with valid/row/col/last after the array latency.
// Ports    : clk, rst_n (async, active-low)
//            cfg_*      - job configuration, sampled with cfg_start in IDLE
//            busy, done - job status (done is a one-cycle pulse)
//            wgt_*      - weight/bias load handshake
//            win_*      - IFM window handshake
//            pe_*       - operands to / result from the PE array
//            ofm_*      - tagged result stream (no backpressure)
// Revision : 1.0 - initial release
// ============================================================================
module pe_arr_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_IFM_WIDTH  = 8,
    parameter int unsigned INPUT_WGT_WIDTH  = 8,
    parameter int unsigned INPUT_BIAS_WIDTH = 8,
    parameter int unsigned OUTPUT_WIDTH     = 20,
    parameter int unsigned PE_ARR_SIZE      = DEF_PE_ARR_SIZE,
    parameter int unsigned PE_LATENCY       = DEF_PE_LATENCY,
    parameter int unsigned DIM_W            = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_start,
    input  logic                                   cfg_reuse_wgt,
    input  logic [DIM_W-1:0]                       cfg_rows,
    input  logic [DIM_W-1:0]                       cfg_cols,
    output logic                                   busy,
    input  logic                                   wgt_valid,
    input  logic [INPUT_WGT_WIDTH-1:0]             wgt_data,
    output logic                                   wgt_ready,
    input  logic                                   win_valid,
    input  logic [PE_ARR_SIZE*INPUT_IFM_WIDTH-1:0] win_data,
    output logic                                   win_ready,
    output logic [PE_ARR_SIZE*INPUT_IFM_WIDTH-1:0] pe_ifm,
    output logic [PE_ARR_SIZE*INPUT_WGT_WIDTH-1:0] pe_wgt,
    output logic [INPUT_BIAS_WIDTH-1:0]            pe_bias,
    input  logic [OUTPUT_WIDTH-1:0]                pe_ofm,
    output logic                                   ofm_valid,
    output logic [OUTPUT_WIDTH-1:0]                ofm_data,
    output logic [DIM_W-1:0]                       ofm_row,
    output logic [DIM_W-1:0]                       ofm_col,
    output logic                                   ofm_last,
    output logic                                   done
);

    localparam int unsigned CNT_W    = $clog2(PE_ARR_SIZE + 1);
    localparam int unsigned TOT_W    = 2 * DIM_W;
    localparam int unsigned BIAS_IDX = PE_ARR_SIZE;

    pe_state_t          r_state;
    pe_state_t          w_state_nxt;
    logic [DIM_W-1:0]   r_rows;
    logic [DIM_W-1:0]   r_cols;
    logic [TOT_W-1:0]   r_total;
    logic [TOT_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_wgt_cnt;
    logic               w_accept;
    logic               w_dly_out;
    logic               w_dly_empty;

    assign w_accept = win_valid && win_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        wgt_ready   = 1'b0;
        win_ready   = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    if (cfg_rows == '0 || cfg_cols == '0) w_state_nxt = ST_DONE;
                    else if (cfg_reuse_wgt)               w_state_nxt = ST_COMPUTE;
                    else                                  w_state_nxt = ST_LOAD_WGT;
                end
            end
            ST_LOAD_WGT: begin
                wgt_ready = 1'b1;
                if (wgt_valid && r_wgt_cnt == CNT_W'(BIAS_IDX)) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                win_ready = 1'b1;
                if (win_valid && r_win_cnt == r_total - TOT_W'(1)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The output register holds the final beat once the line empties.
                if (w_dly_empty) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: config latch, weight/bias load, window capture, output tags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows    <= '0;
            r_cols    <= '0;
            r_total   <= '0;
            r_win_cnt <= '0;
            r_wgt_cnt <= '0;
            pe_ifm    <= '0;
            pe_wgt    <= '0;
            pe_bias   <= '0;
            ofm_valid <= 1'b0;
            ofm_row   <= '0;
            ofm_col   <= '0;
        end else begin
            ofm_valid <= w_dly_out;

            if (r_state == ST_IDLE && cfg_start) begin
                r_rows    <= cfg_rows;
                r_cols    <= cfg_cols;
                r_total   <= {{DIM_W{1'b0}}, cfg_rows} * {{DIM_W{1'b0}}, cfg_cols};
                r_win_cnt <= '0;
                r_wgt_cnt <= '0;
                ofm_row   <= '0;
                ofm_col   <= '0;
            end

            if (wgt_valid && wgt_ready) begin
                if (r_wgt_cnt == CNT_W'(BIAS_IDX)) begin
                    pe_bias <= wgt_data[INPUT_BIAS_WIDTH-1:0];
                end
                for (int k = 0; k < int'(PE_ARR_SIZE); k++) begin
                    if (r_wgt_cnt == CNT_W'(k)) begin
                        pe_wgt[k*INPUT_WGT_WIDTH +: INPUT_WGT_WIDTH] <= wgt_data;
                    end
                end
                r_wgt_cnt <= r_wgt_cnt + CNT_W'(1);
            end

            // Bubbles leave pe_ifm untouched so the array sees stable operands.
            if (w_accept) begin
                pe_ifm    <= win_data;
                r_win_cnt <= r_win_cnt + TOT_W'(1);
            end

            if (ofm_valid) begin
                if (ofm_col == r_cols - DIM_W'(1)) begin
                    ofm_col <= '0;
                    ofm_row <= ofm_row + DIM_W'(1);
                end else begin
                    ofm_col <= ofm_col + DIM_W'(1);
                end
            end
        end
    end

    // Accept at edge t+1 enters stage 0; the output register adds the final
    // cycle so the tag lines up with pe_ofm PE_LATENCY cycles after pe_ifm.
    pe_valid_delay #(
        .DEPTH (PE_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (w_accept),
        .out_vld (w_dly_out),
        .empty   (w_dly_empty)
    );

    assign ofm_data = ofm_valid ? pe_ofm : '0;
    assign ofm_last = ofm_valid && (ofm_row == r_rows - DIM_W'(1))
                                && (ofm_col == r_cols - DIM_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_pe_arr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_arr_ctrl
// Purpose  : Directed self-checking bench for pe_arr_ctrl with a behavioural
//            PE array (signed dot product plus bias, fixed latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_arr_ctrl;
    import pe_ctrl_pkg::*;

    localparam int IW  = 8;
    localparam int WW  = 8;
    localparam int BW  = 8;
    localparam int OW  = 20;
    localparam int N   = DEF_PE_ARR_SIZE;
    localparam int LAT = DEF_PE_LATENCY;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start, cfg_reuse_wgt;
    logic [DW-1:0]     cfg_rows, cfg_cols;
    logic              busy, wgt_valid, wgt_ready, win_valid, win_ready;
    logic [WW-1:0]     wgt_data;
    logic [N*IW-1:0]   win_data, pe_ifm;
    logic [N*WW-1:0]   pe_wgt;
    logic [BW-1:0]     pe_bias;
    logic [OW-1:0]     pe_ofm, ofm_data;
    logic              ofm_valid, ofm_last, done;
    logic [DW-1:0]     ofm_row, ofm_col;

    always #5 clk = ~clk;

    pe_arr_ctrl #(
        .INPUT_IFM_WIDTH (IW), .INPUT_WGT_WIDTH (WW), .INPUT_BIAS_WIDTH (BW),
        .OUTPUT_WIDTH (OW), .PE_ARR_SIZE (N), .PE_LATENCY (LAT), .DIM_W (DW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .cfg_start (cfg_start),
        .cfg_reuse_wgt (cfg_reuse_wgt), .cfg_rows (cfg_rows), .cfg_cols (cfg_cols),
        .busy (busy), .wgt_valid (wgt_valid), .wgt_data (wgt_data),
        .wgt_ready (wgt_ready), .win_valid (win_valid), .win_data (win_data),
        .win_ready (win_ready), .pe_ifm (pe_ifm), .pe_wgt (pe_wgt),
        .pe_bias (pe_bias), .pe_ofm (pe_ofm), .ofm_valid (ofm_valid),
        .ofm_data (ofm_data), .ofm_row (ofm_row), .ofm_col (ofm_col),
        .ofm_last (ofm_last), .done (done)
    );

    // ---------------- behavioural PE array ----------------
    function automatic logic signed [OW-1:0] pe_sum(input logic [N*IW-1:0] ifm,
                                                    input logic [N*WW-1:0] wgt,
                                                    input logic [BW-1:0]   b);
        logic signed [OW-1:0] acc;
        acc = {{(OW-BW){b[BW-1]}}, b};
        for (int k = 0; k < N; k++)
            acc = acc + $signed(ifm[k*IW +: IW]) * $signed(wgt[k*WW +: WW]);
        return acc;
    endfunction

    logic signed [OW-1:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= pe_sum(pe_ifm, pe_wgt, pe_bias);
        end
    end
    assign pe_ofm = pipe[LAT-1];

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [OW-1:0] data;
        logic [DW-1:0] row;
        logic [DW-1:0] col;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t          beats[$];
    int             checks = 0, failures = 0;
    int             cyc = 0, start_cyc = 0, done_cyc = -1, done_cnt = 0;
    int             wgt_seen = 0, win_seen = 0;
    bit             timeout = 0;
    int             acc_cyc [0:15];
    logic [WW-1:0]  wv   [0:N];
    logic [N*IW-1:0] wins [0:7];

    // Advance one cycle and record what the DUT shows in that cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ofm_valid) beats.push_back('{ofm_data, ofm_row, ofm_col, ofm_last, cyc});
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (wgt_ready) wgt_seen++;
        if (win_ready) win_seen++;
    endtask

    task automatic clear_mon();
        beats.delete();
        done_cnt = 0; done_cyc = -1; wgt_seen = 0; win_seen = 0; timeout = 0;
    endtask

    task automatic start_job(input int rows, input int cols, input bit reuse);
        cfg_rows = DW'(rows); cfg_cols = DW'(cols); cfg_reuse_wgt = reuse;
        cfg_start = 1'b1; start_cyc = cyc;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic load_wgts();
        int k = 0; int g = 0; bit acc;
        while (k <= int'(BIAS_WORD_IDX) && g < 200) begin
            wgt_valid = 1'b1; wgt_data = wv[k]; acc = wgt_ready;
            step();
            if (acc) k++;
            g++;
        end
        wgt_valid = 1'b0;
        if (k <= int'(BIAS_WORD_IDX)) timeout = 1;
    endtask

    task automatic send_wins(input int n, input bit bubble);
        int i = 0; int g = 0; bit tog = 0;
        while (i < n && g < 500) begin
            if (bubble && tog) win_valid = 1'b0;
            else begin
                win_valid = 1'b1; win_data = wins[i];
                if (win_ready) begin acc_cyc[i] = cyc; i++; end
            end
            step();
            tog = ~tog; g++;
        end
        win_valid = 1'b0;
        if (i < n) timeout = 1;
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_cnt == 0 && g < 100) begin step(); g++; end
        if (done_cnt == 0) timeout = 1;
        repeat (3) step();
    endtask

    task automatic set_unit_weights();
        for (int k = 0; k < N; k++) wv[k] = WW'(k + 1);
        wv[N] = 8'd1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, wgt_ready, win_ready, ofm_valid, ofm_last, done} !== 6'b0) begin
            failures++; $display("FAIL reset_ctl: got %b expected 000000", {busy, wgt_ready, win_ready, ofm_valid, ofm_last, done}); end
        checks++; if (pe_wgt !== '0 || pe_bias !== '0) begin
            failures++; $display("FAIL reset_wgt: got %h/%h expected 0/0", pe_wgt, pe_bias); end
        checks++; if (pe_ifm !== '0) begin
            failures++; $display("FAIL reset_ifm: got %h expected 0", pe_ifm); end
        checks++; if ({ofm_data, ofm_row, ofm_col} !== '0) begin
            failures++; $display("FAIL reset_ofm: got %h/%0d/%0d expected 0", ofm_data, ofm_row, ofm_col); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sanity(input string tag);
        set_unit_weights();
        for (int k = 0; k < N; k++) wins[0][k*IW +: IW] = IW'(k + 1);
        clear_mon();
        start_job(1, 1, 0);
        load_wgts();
        checks++; if (pe_wgt !== 72'h090807060504030201 || pe_bias !== 8'd1) begin
            failures++; $display("FAIL %s_load: got %h/%h expected 090807060504030201/01", tag, pe_wgt, pe_bias); end
        send_wins(1, 0);
        wait_done();
        checks++; if (timeout || beats.size() != 1 || done_cnt != 1) begin
            failures++; $display("FAIL %s_count: got beats=%0d done=%0d to=%0d expected 1/1/0", tag, beats.size(), done_cnt, timeout); end
        if (beats.size() >= 1) begin
            checks++; if (beats[0].data !== OW'(286)) begin
                failures++; $display("FAIL %s_data: got %0d expected 286", tag, beats[0].data); end
            checks++; if ({beats[0].row, beats[0].col, beats[0].last} !== {8'd0, 8'd0, 1'b1}) begin
                failures++; $display("FAIL %s_tag: got r%0d c%0d l%b expected r0 c0 l1", tag, beats[0].row, beats[0].col, beats[0].last); end
            checks++; if (beats[0].cyc - acc_cyc[0] != LAT + 1) begin
                failures++; $display("FAIL %s_latency: got %0d expected %0d", tag, beats[0].cyc - acc_cyc[0], LAT + 1); end
            checks++; if (done_cyc != beats[0].cyc + 1) begin
                failures++; $display("FAIL %s_done_time: got %0d expected %0d", tag, done_cyc, beats[0].cyc + 1); end
        end
    endtask

    task automatic run_2x3(input string tag, input bit bubble);
        int exp_d [6] = '{46, 91, 136, 181, 226, 271};
        int exp_r [6] = '{0, 0, 0, 1, 1, 1};
        int exp_c [6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) wins[i] = {N{IW'(i + 1)}};
        clear_mon();
        start_job(2, 3, bubble);
        if (!bubble) load_wgts();
        send_wins(6, bubble);
        wait_done();
        checks++; if (timeout || beats.size() != 6 || done_cnt != 1) begin
            failures++; $display("FAIL %s_count: got beats=%0d done=%0d to=%0d expected 6/1/0", tag, beats.size(), done_cnt, timeout); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            checks++; if (beats[i].data !== OW'(exp_d[i])) begin
                failures++; $display("FAIL %s_data%0d: got %0d expected %0d", tag, i, beats[i].data, exp_d[i]); end
            checks++; if ({beats[i].row, beats[i].col, beats[i].last} !== {DW'(exp_r[i]), DW'(exp_c[i]), (i == 5)}) begin
                failures++; $display("FAIL %s_tag%0d: got r%0d c%0d l%b expected r%0d c%0d l%b", tag, i,
                    beats[i].row, beats[i].col, beats[i].last, exp_r[i], exp_c[i], (i == 5)); end
            checks++; if (beats[i].cyc != acc_cyc[i] + LAT + 1) begin
                failures++; $display("FAIL %s_time%0d: got %0d expected %0d", tag, i, beats[i].cyc, acc_cyc[i] + LAT + 1); end
            if (i > 0) begin
                checks++; if (beats[i].cyc - beats[i-1].cyc != (bubble ? 2 : 1)) begin
                    failures++; $display("FAIL %s_gap%0d: got %0d expected %0d", tag, i, beats[i].cyc - beats[i-1].cyc, bubble ? 2 : 1); end
            end
        end
    endtask

    task automatic test_streaming(); run_2x3("stream", 1'b0); endtask
    task automatic test_bubbles();   run_2x3("bubble", 1'b1); endtask

    task automatic test_reuse_signed();
        for (int k = 0; k < N; k++) wv[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
        wv[N] = 8'hFD;
        wins[0] = {N{8'h01}};
        clear_mon();
        start_job(1, 1, 0);
        load_wgts();
        send_wins(1, 0);
        wait_done();
        checks++; if (beats.size() != 1 || beats[0].data !== OW'(-135)) begin
            failures++; $display("FAIL signed_load_job: got n=%0d d=%h expected 1/%h", beats.size(),
                beats.size() > 0 ? beats[0].data : '0, OW'(-135)); end
        wins[0] = {N{8'hFF}};
        wins[1] = 72'h80;
        clear_mon();
        start_job(1, 2, 1);
        send_wins(2, 0);
        wait_done();
        checks++; if (wgt_seen != 0) begin
            failures++; $display("FAIL reuse_wgt_ready: got %0d cycles expected 0", wgt_seen); end
        checks++; if (timeout || beats.size() != 2 || done_cnt != 1) begin
            failures++; $display("FAIL reuse_count: got beats=%0d done=%0d to=%0d expected 2/1/0", beats.size(), done_cnt, timeout); end
        if (beats.size() == 2) begin
            checks++; if (beats[0].data !== OW'(129) || beats[1].data !== OW'(16381)) begin
                failures++; $display("FAIL reuse_data: got %0d,%0d expected 129,16381", beats[0].data, beats[1].data); end
            checks++; if ({beats[0].col, beats[0].last, beats[1].col, beats[1].last} !== {8'd0, 1'b0, 8'd1, 1'b1}) begin
                failures++; $display("FAIL reuse_tag: got c%0d l%b c%0d l%b expected c0 l0 c1 l1",
                    beats[0].col, beats[0].last, beats[1].col, beats[1].last); end
        end
    endtask

    task automatic test_zero_size();
        clear_mon();
        start_job(0, 4, 0);
        wait_done();
        checks++; if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
            failures++; $display("FAIL zero_done: got n=%0d at %0d expected 1 at %0d", done_cnt, done_cyc, start_cyc + 1); end
        checks++; if (wgt_seen != 0 || win_seen != 0 || beats.size() != 0) begin
            failures++; $display("FAIL zero_quiet: got wgt=%0d win=%0d ofm=%0d expected 0/0/0", wgt_seen, win_seen, beats.size()); end
    endtask

    task automatic test_reset_mid_job();
        set_unit_weights();
        wins[0] = {N{8'd1}};
        wins[1] = {N{8'd2}};
        clear_mon();
        start_job(1, 2, 0);
        load_wgts();
        send_wins(2, 0);
        step(); step();
        checks++; if (!busy || win_ready || wgt_ready || beats.size() != 0) begin
            failures++; $display("FAIL mid_in_drain: got busy=%b win=%b wgt=%b ofm=%0d expected 1/0/0/0", busy, win_ready, wgt_ready, beats.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, wgt_ready, win_ready, ofm_valid, ofm_last, done} !== 6'b0) begin
            failures++; $display("FAIL mid_rst_ctl: got %b expected 000000", {busy, wgt_ready, win_ready, ofm_valid, ofm_last, done}); end
        checks++; if (pe_wgt !== '0 || pe_bias !== '0 || pe_ifm !== '0 || ofm_data !== '0) begin
            failures++; $display("FAIL mid_rst_data: got %h/%h/%h/%h expected 0", pe_wgt, pe_bias, pe_ifm, ofm_data); end
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        checks++; if (done_cnt != 0 || beats.size() != 0) begin
            failures++; $display("FAIL mid_rst_quiet: got done=%0d ofm=%0d expected 0/0", done_cnt, beats.size()); end
        test_sanity("after_rst");
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_reuse_wgt = 1'b0; cfg_rows = '0; cfg_cols = '0;
        wgt_valid = 1'b0; wgt_data = '0; win_valid = 1'b0; win_data = '0;
        for (int i = 0; i < 16; i++) acc_cyc[i] = 0;
        test_reset();
        test_sanity("sanity");
        test_streaming();
        test_bubbles();
        test_reuse_signed();
        test_zero_size();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
